// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding select
// encodings and the default widths of the per-stage control-tracking record.
package hazard_pipe_ctrl_pkg;

  localparam int FWD_SEL_W = 2;

  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b10;
  localparam logic [FWD_SEL_W-1:0] FWD_EX  = 2'b11;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 18;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/hazard_pipe_ctrl_fwd_select.sv
// Per-operand forwarding select: compares one ID source address against the
// EX/MEM/WB destinations and picks the youngest qualified producer.
module fwd_select
  import hazard_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic                 id_valid,
  input  logic                 uses,
  input  logic [REG_AW-1:0]    src,
  input  logic                 ex_src,
  input  logic                 mem_src,
  input  logic                 wb_src,
  input  logic [REG_AW-1:0]    ex_dest,
  input  logic [REG_AW-1:0]    mem_dest,
  input  logic [REG_AW-1:0]    wb_dest,
  output logic [FWD_SEL_W-1:0] sel,
  output logic                 ex_hit,
  output logic                 mem_hit
);

  logic live;
  logic wb_hit;

  // ex_src/mem_src/wb_src already exclude r0 and non-writing stages
  assign live    = id_valid & uses;
  assign ex_hit  = live & ex_src  & (ex_dest  == src);
  assign mem_hit = live & mem_src & (mem_dest == src);
  assign wb_hit  = live & wb_src  & (wb_dest  == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else if (wb_hit)  sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// EX/MEM/WB control-tracking registers with operand forwarding, load-use
// stall generation (1- or 2-cycle load latency) and flush bubble insertion.
module hazard_pipe_ctrl
  import hazard_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REG_AW-1:0]    id_dest,
  input  logic                 id_rf_enable,
  input  logic                 id_load,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 flush,
  output logic [FWD_SEL_W-1:0] pa_selector,
  output logic [FWD_SEL_W-1:0] pb_selector,
  output logic                 pc_enable,
  output logic                 load_enable,
  output logic                 nop_signal,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [CTRL_W-1:0]    mem_ctrl,
  output logic [CTRL_W-1:0]    wb_ctrl,
  output logic [REG_AW-1:0]    ex_dest,
  output logic [REG_AW-1:0]    mem_dest,
  output logic [REG_AW-1:0]    wb_dest,
  output logic                 wb_rf_enable,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam bit MEM_LOAD_STALL = (MEM_LAT == 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic ex_vld, ex_rf, ex_ld;
  logic mem_vld, mem_rf, mem_ld;
  logic wb_vld;
  logic ex_src, mem_src, wb_src;
  logic ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b;
  logic hazard, stall;

  assign ex_src  = ex_vld  & ex_rf        & (|ex_dest);
  assign mem_src = mem_vld & mem_rf       & (|mem_dest);
  assign wb_src  = wb_vld  & wb_rf_enable & (|wb_dest);

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .id_valid (id_valid),
    .uses     (id_uses_rs),
    .src      (id_rs),
    .ex_src   (ex_src),
    .mem_src  (mem_src),
    .wb_src   (wb_src),
    .ex_dest  (ex_dest),
    .mem_dest (mem_dest),
    .wb_dest  (wb_dest),
    .sel      (pa_selector),
    .ex_hit   (ex_hit_a),
    .mem_hit  (mem_hit_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .id_valid (id_valid),
    .uses     (id_uses_rt),
    .src      (id_rt),
    .ex_src   (ex_src),
    .mem_src  (mem_src),
    .wb_src   (wb_src),
    .ex_dest  (ex_dest),
    .mem_dest (mem_dest),
    .wb_dest  (wb_dest),
    .sel      (pb_selector),
    .ex_hit   (ex_hit_b),
    .mem_hit  (mem_hit_b)
  );

  // A load still in MEM only blocks the consumer when its data lands a cycle later
  assign hazard = (ex_ld & (ex_hit_a | ex_hit_b)) |
                  (MEM_LOAD_STALL & mem_ld & (mem_hit_a | mem_hit_b));
  assign stall  = hazard & id_valid & ~flush;

  assign pc_enable   = ~stall;
  assign load_enable = ~stall;
  assign nop_signal  = stall | flush;

  // ID -> EX -> MEM -> WB stage boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_vld       <= 1'b0;
      ex_rf        <= 1'b0;
      ex_ld        <= 1'b0;
      ex_dest      <= '0;
      ex_ctrl      <= '0;
      mem_vld      <= 1'b0;
      mem_rf       <= 1'b0;
      mem_ld       <= 1'b0;
      mem_dest     <= '0;
      mem_ctrl     <= '0;
      wb_vld       <= 1'b0;
      wb_rf_enable <= 1'b0;
      wb_dest      <= '0;
      wb_ctrl      <= '0;
      stall_cycles <= '0;
    end else begin
      wb_vld       <= mem_vld;
      wb_rf_enable <= mem_rf;
      wb_dest      <= mem_dest;
      wb_ctrl      <= mem_ctrl;
      mem_vld      <= ex_vld;
      mem_rf       <= ex_rf;
      mem_ld       <= ex_ld;
      mem_dest     <= ex_dest;
      mem_ctrl     <= ex_ctrl;
      if (stall | flush) begin
        ex_vld  <= 1'b0;
        ex_rf   <= 1'b0;
        ex_ld   <= 1'b0;
        ex_dest <= '0;
        ex_ctrl <= '0;
      end else begin
        ex_vld  <= id_valid;
        ex_rf   <= id_rf_enable;
        ex_ld   <= id_load;
        ex_dest <= id_dest;
        ex_ctrl <= id_ctrl;
      end
      if (stall) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: a MEM_LAT=1 and a MEM_LAT=2 instance share the
// same stimulus and are compared every cycle against a record-list model.
module tb_hazard_pipe_ctrl;
  localparam int AW = 5;
  localparam int CW = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_rf_enable = 1'b0, id_load = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] id_ctrl = '0;

  logic [1:0] pa_a, pb_a, pa_b, pb_b;
  logic pc_a, le_a, nop_a, wrf_a, pc_b, le_b, nop_b, wrf_b;
  logic [CW-1:0] exc_a, mc_a, wc_a, exc_b, mc_b, wc_b;
  logic [AW-1:0] exd_a, md_a, wd_a, exd_b, md_b, wd_b;
  logic [15:0] sc_a;
  logic [3:0] sc_b;

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.REG_AW(AW), .CTRL_W(CW), .MEM_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_rf_enable(id_rf_enable), .id_load(id_load), .id_ctrl(id_ctrl), .flush(flush),
    .pa_selector(pa_a), .pb_selector(pb_a), .pc_enable(pc_a), .load_enable(le_a),
    .nop_signal(nop_a), .ex_ctrl(exc_a), .mem_ctrl(mc_a), .wb_ctrl(wc_a),
    .ex_dest(exd_a), .mem_dest(md_a), .wb_dest(wd_a), .wb_rf_enable(wrf_a),
    .stall_cycles(sc_a));

  hazard_pipe_ctrl #(.REG_AW(AW), .CTRL_W(CW), .MEM_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_rf_enable(id_rf_enable), .id_load(id_load), .id_ctrl(id_ctrl), .flush(flush),
    .pa_selector(pa_b), .pb_selector(pb_b), .pc_enable(pc_b), .load_enable(le_b),
    .nop_signal(nop_b), .ex_ctrl(exc_b), .mem_ctrl(mc_b), .wb_ctrl(wc_b),
    .ex_dest(exd_b), .mem_dest(md_b), .wb_dest(wd_b), .wb_rf_enable(wrf_b),
    .stall_cycles(sc_b));

  // Model: per instance, the instructions now in EX (0), MEM (1), WB (2)
  typedef struct {
    bit vld;
    int dest;
    bit rf;
    bit ld;
    logic [CW-1:0] ctrl;
  } rec_t;

  rec_t st[2][3];
  int cnt[2];
  int cnt_max[2];
  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  function automatic rec_t mk(bit v, int d, bit r, bit l, logic [CW-1:0] c);
    rec_t x;
    x.vld = v; x.dest = d; x.rf = r; x.ld = l; x.ctrl = c;
    return x;
  endfunction

  function automatic bit is_src(int m, int i);
    return st[m][i].vld && st[m][i].rf && st[m][i].dest != 0;
  endfunction

  function automatic logic [1:0] exp_sel(int m, bit uses, int addr);
    if (!id_valid || !uses) return 2'b00;
    for (int i = 0; i < 3; i++)
      if (is_src(m, i) && st[m][i].dest == addr)
        return (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // Instance m has load latency m+1: loads in stages 0..m block a consumer
  function automatic bit exp_stall(int m);
    bit haz = 0;
    for (int i = 0; i <= m; i++)
      if (is_src(m, i) && st[m][i].ld &&
          ((id_uses_rs && st[m][i].dest == int'(id_rs)) ||
           (id_uses_rt && st[m][i].dest == int'(id_rt))))
        haz = 1;
    return haz && id_valid && !flush;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  initial begin
    cnt_max[0] = 65535;
    cnt_max[1] = 15;
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      for (int i = 0; i < 3; i++) st[m][i] = mk(0, 0, 0, 0, '0);
    end
    forever begin
      bit s[2];
      @(posedge clk);
      s[0] = exp_stall(0);
      s[1] = exp_stall(1);
      for (int m = 0; m < 2; m++) begin
        if (reset) begin
          for (int i = 0; i < 3; i++) st[m][i] = mk(0, 0, 0, 0, '0);
          cnt[m] = 0;
        end else begin
          st[m][2] = st[m][1];
          st[m][1] = st[m][0];
          if (s[m] || flush) st[m][0] = mk(0, 0, 0, 0, '0);
          else st[m][0] = mk(id_valid, int'(id_dest), id_rf_enable, id_load, id_ctrl);
          if (s[m] && cnt[m] < cnt_max[m]) cnt[m]++;
        end
      end
    end
  end

  task automatic cmp(int m, string t, logic [1:0] pa, logic [1:0] pb, logic pc, logic le,
                     logic nop, logic [CW-1:0] exc, logic [CW-1:0] mc, logic [CW-1:0] wc,
                     logic [AW-1:0] exd, logic [AW-1:0] md, logic [AW-1:0] wd,
                     logic wrf, int sc);
    bit s = exp_stall(m);
    check({t, "pa_selector"}, pa, exp_sel(m, id_uses_rs, int'(id_rs)));
    check({t, "pb_selector"}, pb, exp_sel(m, id_uses_rt, int'(id_rt)));
    check({t, "pc_enable"}, pc, !s);
    check({t, "load_enable"}, le, !s);
    check({t, "nop_signal"}, nop, s || flush);
    check({t, "ex_ctrl"}, exc, st[m][0].ctrl);
    check({t, "mem_ctrl"}, mc, st[m][1].ctrl);
    check({t, "wb_ctrl"}, wc, st[m][2].ctrl);
    check({t, "ex_dest"}, exd, st[m][0].dest);
    check({t, "mem_dest"}, md, st[m][1].dest);
    check({t, "wb_dest"}, wd, st[m][2].dest);
    check({t, "wb_rf_enable"}, wrf, st[m][2].rf);
    check({t, "stall_cycles"}, sc, cnt[m]);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      cmp(0, "lat1 ", pa_a, pb_a, pc_a, le_a, nop_a, exc_a, mc_a, wc_a,
          exd_a, md_a, wd_a, wrf_a, int'(sc_a));
      cmp(1, "lat2 ", pa_b, pb_b, pc_b, le_b, nop_b, exc_b, mc_b, wc_b,
          exd_b, md_b, wd_b, wrf_b, int'(sc_b));
    end
  end

  task automatic put(bit v, int rs, int rt, bit ur, bit ut, int dest, bit rf, bit ld,
                     int ctrl, bit fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = ur; id_uses_rt = ut;
    id_dest = AW'(dest); id_rf_enable = rf; id_load = ld; id_ctrl = CW'(ctrl); flush = fl;
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hold();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst pa_a", pa_a, 0);
    check("rst pc_a", pc_a, 1);
    check("rst sc_a", sc_a, 0);
    check("rst exc_b", exc_b, 0);
    check("rst wd_b", wd_b, 0);

    // forwarding priority and r0 filter
    put(1, 0, 0, 0, 0, 3, 1, 0, 'h11, 0);
    put(1, 3, 0, 1, 0, 3, 1, 0, 'h12, 0);
    @(negedge clk); check("ex fwd pa_a", pa_a, 2'b11);
    put(1, 3, 0, 1, 0, 7, 1, 0, 'h13, 0);
    @(negedge clk); check("ex over mem pa_a", pa_a, 2'b11); check("ex over mem pa_b", pa_b, 2'b11);
    put(1, 3, 0, 1, 0, 0, 1, 0, 'h14, 0);
    @(negedge clk); check("mem fwd pa_a", pa_a, 2'b01);
    put(1, 3, 0, 1, 0, 6, 1, 0, 'h15, 0);
    @(negedge clk); check("wb fwd pa_a", pa_a, 2'b10);
    put(1, 0, 0, 0, 0, 0, 1, 1, 'h16, 0);
    put(1, 0, 0, 1, 0, 4, 1, 0, 'h17, 0);
    @(negedge clk); check("r0 pa_a", pa_a, 2'b00); check("r0 pc_a", pc_a, 1);
    check("r0 pc_b", pc_b, 1);
    repeat (3) idle();

    // adjacent load-use
    put(1, 0, 0, 0, 0, 5, 1, 1, 'h33, 0);
    put(1, 0, 5, 0, 1, 8, 1, 0, 'h44, 0);
    @(negedge clk); check("lu pc_a", pc_a, 0); check("lu nop_a", nop_a, 1);
    check("lu pc_b", pc_b, 0);
    hold();
    @(negedge clk); check("lu bubble exc_a", exc_a, 0); check("lu after pc_a", pc_a, 1);
    check("lu after pb_a", pb_a, 2'b01); check("lu count sc_a", sc_a, 1);
    check("lu2 pc_b", pc_b, 0); check("lu2 pb_b", pb_b, 2'b01);
    hold();
    @(negedge clk); check("lu2 after pc_b", pc_b, 1); check("lu2 after pb_b", pb_b, 2'b10);
    check("lu2 count sc_b", sc_b, 2);
    repeat (3) idle();

    // load-use with one instruction gap
    put(1, 0, 0, 0, 0, 5, 1, 1, 'h33, 0);
    put(1, 0, 0, 0, 0, 9, 1, 0, 'h55, 0);
    put(1, 5, 0, 1, 0, 10, 1, 0, 'h66, 0);
    @(negedge clk); check("gap pc_b", pc_b, 0); check("gap pc_a", pc_a, 1);
    check("gap pa_a", pa_a, 2'b01);
    hold();
    @(negedge clk); check("gap after pc_b", pc_b, 1); check("gap after pa_b", pa_b, 2'b10);
    check("gap count sc_b", sc_b, 3);
    repeat (3) idle();

    // flush beats stall
    put(1, 0, 0, 0, 0, 5, 1, 1, 'h33, 0);
    put(1, 5, 0, 1, 0, 11, 1, 0, 'h77, 1);
    @(negedge clk); check("fl pc_a", pc_a, 1); check("fl nop_a", nop_a, 1);
    check("fl pc_b", pc_b, 1); check("fl nop_b", nop_b, 1);
    idle();
    @(negedge clk); check("fl exc_a", exc_a, 0); check("fl exd_a", exd_a, 0);
    check("fl mc_a", mc_a, 'h33);
    repeat (3) idle();

    // reset in the middle of a stall
    put(1, 0, 0, 0, 0, 5, 1, 1, 'h33, 0);
    put(1, 5, 0, 1, 0, 12, 1, 0, 'h88, 0);
    @(negedge clk); check("rs stall pc_a", pc_a, 0);
    reset = 1'b1;
    hold();
    reset = 1'b0;
    @(negedge clk); check("rs pc_a", pc_a, 1); check("rs pc_b", pc_b, 1);
    check("rs exc_a", exc_a, 0); check("rs md_a", md_a, 0); check("rs wc_b", wc_b, 0);
    check("rs sc_a", sc_a, 0);

    // randomized traffic, small register space to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 299) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      id_uses_rs = $urandom_range(0, 1);
      id_uses_rt = $urandom_range(0, 1);
      id_dest = AW'($urandom_range(0, 3));
      id_rf_enable = ($urandom_range(0, 3) != 0);
      id_load = $urandom_range(0, 1);
      id_ctrl = CW'($urandom);
      flush = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
